// File: rtl/rr_onehot_grant_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_onehot_grant_arbiter
// Brief    : Round-robin arbiter with packet lock; registered one-hot grant.
// Revision : 1.0 - initial release
// ============================================================================
module rr_onehot_grant_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] io_in_valid,
    input  logic [N-1:0] io_in_last,
    output logic [N-1:0] io_in_ready,
    output logic         io_out_valid,
    input  logic         io_out_ready,
    output logic         io_out_last,
    output logic [N-1:0] io_out_grant_oh
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [N-1:0] c_one     = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] c_ptr_rst = {1'b1, {(N-1){1'b0}}};

    state_t       r_state;
    state_t       w_state_nxt;
    logic [N-1:0] r_grant_oh;
    logic [N-1:0] w_grant_nxt;
    logic [N-1:0] r_ptr_oh;
    logic [N-1:0] w_ptr_nxt;

    logic [N-1:0] w_hi_mask;
    logic [N-1:0] w_req_hi;
    logic [N-1:0] w_pick_hi;
    logic [N-1:0] w_pick_all;
    logic [N-1:0] w_winner_oh;
    logic         w_xfer_last;

    // Requests strictly above the last winner take priority; otherwise wrap to
    // the lowest valid index. x & -x isolates the lowest set bit.
    assign w_hi_mask   = ~((r_ptr_oh << 1) - c_one);
    assign w_req_hi    = io_in_valid & w_hi_mask;
    assign w_pick_hi   = w_req_hi & (~w_req_hi + c_one);
    assign w_pick_all  = io_in_valid & (~io_in_valid + c_one);
    assign w_winner_oh = (|w_req_hi) ? w_pick_hi : w_pick_all;

    // Grant is all-zero while idle, so these collapse to zero outside BUSY.
    assign io_out_valid    = |(io_in_valid & r_grant_oh);
    assign io_out_last     = |(io_in_valid & io_in_last & r_grant_oh);
    assign io_in_ready     = r_grant_oh & {N{io_out_ready}};
    assign io_out_grant_oh = r_grant_oh;
    assign w_xfer_last     = io_out_last & io_out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_grant_oh <= '0;
            r_ptr_oh   <= c_ptr_rst;
        end else begin
            r_state    <= w_state_nxt;
            r_grant_oh <= w_grant_nxt;
            r_ptr_oh   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant_oh;
        w_ptr_nxt   = r_ptr_oh;
        case (r_state)
            ST_IDLE: begin
                if (|io_in_valid) begin
                    w_state_nxt = ST_BUSY;
                    w_grant_nxt = w_winner_oh;
                end
            end
            ST_BUSY: begin
                // Lock holds until the granted requester's last beat is accepted.
                if (w_xfer_last) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                    w_ptr_nxt   = r_grant_oh;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    a_grant_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(r_grant_oh));

endmodule
`default_nettype wire

// File: tb/tb_rr_onehot_grant_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_onehot_grant_arbiter
// Brief    : Directed + randomized check of rr_onehot_grant_arbiter vs model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_onehot_grant_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] io_in_valid;
    logic [N-1:0] io_in_last;
    logic [N-1:0] io_in_ready;
    logic         io_out_valid;
    logic         io_out_ready;
    logic         io_out_last;
    logic [N-1:0] io_out_grant_oh;

    rr_onehot_grant_arbiter #(.N(N)) u_dut (
        .clk             (clk),
        .reset           (reset),
        .io_in_valid     (io_in_valid),
        .io_in_last      (io_in_last),
        .io_in_ready     (io_in_ready),
        .io_out_valid    (io_out_valid),
        .io_out_ready    (io_out_ready),
        .io_out_last     (io_out_last),
        .io_out_grant_oh (io_out_grant_oh)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: index of current grant (-1 when idle) and last winner.
    int m_grant;
    int m_last;

    // Starvation tracking on observed grants.
    int           skip [N];
    int           max_skip;
    logic         prev_idle;
    logic [N-1:0] prev_idle_valid;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_grant", 32'(io_out_grant_oh), 32'd0);
        chk("rst_valid", 32'(io_out_valid), 32'd0);
        chk("rst_ready", 32'(io_in_ready), 32'd0);
        chk("rst_last",  32'(io_out_last), 32'd0);
        m_grant   = -1;
        m_last    = N - 1;
        prev_idle = 1'b0;
        for (int i = 0; i < N; i++) skip[i] = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Entered 1 time unit after a rising edge; returns at the same phase.
    task automatic step(input logic [N-1:0] v, input logic [N-1:0] l, input logic r,
                        output logic [N-1:0] g_obs);
        logic [N-1:0] eg;
        logic [N-1:0] er;
        logic         ev;
        logic         el;
        logic         found;
        int           idx;
        io_in_valid  = v;
        io_in_last   = l;
        io_out_ready = r;
        #3;
        eg = '0;
        er = '0;
        ev = 1'b0;
        el = 1'b0;
        if (m_grant >= 0) begin
            eg[m_grant] = 1'b1;
            ev = v[m_grant];
            el = v[m_grant] & l[m_grant];
            if (r) er[m_grant] = 1'b1;
        end
        chk("grant",     32'(io_out_grant_oh), 32'(eg));
        chk("out_valid", 32'(io_out_valid),    32'(ev));
        chk("out_last",  32'(io_out_last),     32'(el));
        chk("in_ready",  32'(io_in_ready),     32'(er));
        g_obs = io_out_grant_oh;

        if (io_out_grant_oh == '0) begin
            prev_idle       = 1'b1;
            prev_idle_valid = v;
        end else if (prev_idle) begin
            for (int i = 0; i < N; i++) begin
                if (prev_idle_valid[i] && !io_out_grant_oh[i]) skip[i]++;
                else skip[i] = 0;
                if (skip[i] > max_skip) max_skip = skip[i];
            end
            prev_idle = 1'b0;
        end

        @(posedge clk);
        #1;
        if (m_grant < 0) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                idx = (m_last + k) % N;
                if (!found && v[idx]) begin
                    m_grant = idx;
                    found   = 1'b1;
                end
            end
        end else if (v[m_grant] && r && l[m_grant]) begin
            m_last  = m_grant;
            m_grant = -1;
        end
    endtask

    logic [N-1:0] g;
    logic [N-1:0] exp_seq [10];
    int           cnt_busy;
    int           ready2_seen;
    int           ovalid_seen;

    initial begin
        reset        = 1'b1;
        io_in_valid  = '0;
        io_in_last   = '0;
        io_out_ready = 1'b0;
        max_skip     = 0;
        @(posedge clk);
        #1;
        do_reset();

        // Sole requester alternates idle/grant.
        for (int i = 0; i < 6; i++) begin
            step(4'b0001, 4'b0001, 1'b1, g);
            chk("solo_seq", 32'(g), (i % 2 == 1) ? 32'd1 : 32'd0);
        end

        // All requesting, single-beat packets: rotating order.
        do_reset();
        exp_seq = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000,
                    4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
        for (int i = 0; i < 10; i++) begin
            step(4'b1111, 4'b1111, 1'b1, g);
            chk("rr_seq", 32'(g), 32'(exp_seq[i]));
        end

        // Three-beat packet from req1 with backpressure; req2 waits.
        do_reset();
        cnt_busy    = 0;
        ready2_seen = 0;
        step(4'b0110, 4'b0000, 1'b1, g);
        step(4'b0110, 4'b0000, 1'b1, g); if (g == 4'b0010) cnt_busy++;
        ready2_seen += int'(io_in_ready[2]);
        step(4'b0110, 4'b0000, 1'b0, g); if (g == 4'b0010) cnt_busy++;
        ready2_seen += int'(io_in_ready[2]);
        step(4'b0110, 4'b0000, 1'b0, g); if (g == 4'b0010) cnt_busy++;
        ready2_seen += int'(io_in_ready[2]);
        step(4'b0110, 4'b0000, 1'b1, g); if (g == 4'b0010) cnt_busy++;
        ready2_seen += int'(io_in_ready[2]);
        step(4'b0110, 4'b0010, 1'b1, g); if (g == 4'b0010) cnt_busy++;
        ready2_seen += int'(io_in_ready[2]);
        chk("lock_cycles", 32'(cnt_busy), 32'd5);
        chk("lock_ready2", 32'(ready2_seen), 32'd0);
        step(4'b0100, 4'b0100, 1'b1, g);
        chk("after_lock_idle", 32'(g), 32'd0);
        step(4'b0100, 4'b0100, 1'b1, g);
        chk("after_lock_grant", 32'(g), 32'b0100);

        // req1 drops valid mid-packet while others request.
        do_reset();
        ovalid_seen = 0;
        step(4'b0010, 4'b0000, 1'b1, g);
        step(4'b0010, 4'b0000, 1'b1, g);
        for (int i = 0; i < 3; i++) begin
            step(4'b1101, 4'b1101, 1'b1, g);
            ovalid_seen += int'(io_out_valid);
            chk("gap_grant", 32'(g), 32'b0010);
        end
        chk("gap_ovalid", 32'(ovalid_seen), 32'd0);
        step(4'b0010, 4'b0010, 1'b1, g);
        step(4'b0000, 4'b0000, 1'b1, g);
        chk("gap_done", 32'(g), 32'd0);

        // Reset while req2 holds the grant.
        do_reset();
        for (int i = 0; i < 5; i++) step(4'b1111, 4'b1111, 1'b1, g);
        chk("pre_rst_grant", 32'(io_out_grant_oh), 32'b0100);
        do_reset();
        step(4'b1111, 4'b1111, 1'b1, g);
        chk("post_rst_idle", 32'(g), 32'd0);
        step(4'b1111, 4'b1111, 1'b1, g);
        chk("post_rst_first", 32'(g), 32'b0001);

        // Randomized traffic against the model.
        do_reset();
        max_skip = 0;
        for (int i = 0; i < 10000; i++) begin
            step(N'($urandom), N'($urandom) & N'($urandom), ($urandom_range(0, 3) != 0), g);
        end
        chk("starvation", 32'(max_skip <= N - 1), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
